// File: rtl/tm1638_pkg.sv
// Shared constants, FSM state type and 7-segment lookup for the TM1638 display driver.
package tm1638_pkg;

    localparam logic [7:0] CMD_MODE = 8'h40;
    localparam logic [7:0] CMD_ADDR = 8'hC0;
    localparam logic [7:0] CMD_CTRL = 8'h80;

    // Byte stream: 0 = mode cmd, 1 = address cmd, 2..17 = display RAM, 18 = control cmd
    localparam logic [4:0] LAST_BYTE = 5'd18;
    localparam logic [4:0] NUM_BYTES = 5'd19;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP,
        DONE
    } state_t;

    // Segments a..g in bits 0..6
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // The strobe window closes after the mode cmd, after the last RAM byte, and after the control cmd
    function automatic logic is_window_end(input logic [4:0] idx);
        return (idx == 5'd0) || (idx == 5'd17) || (idx == LAST_BYTE);
    endfunction

endpackage

// File: rtl/tm1638_seg_decode.sv
// One digit: hex nibble plus decimal point to TM1638 segment byte; blank forces all segments off.
module tm1638_seg_decode
    import tm1638_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    assign seg = blank ? 8'h00 : {dp, SEG_LUT[nibble]};

endmodule

// File: rtl/tm1638_multi_driver.sv
// TM1638 refresh engine: mode cmd, 16-byte display RAM burst, control cmd, bit-banged on clk1/dio/stb.
// Define TM1638_LED_EN to add the led port and drive the discrete LEDs at the odd RAM addresses.
module tm1638_multi_driver
    import tm1638_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_DIV    = 50,
    parameter int STB_GAP    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [NUM_DIGITS*4-1:0] hex,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic [2:0]              bright,
    input  logic                    disp_on,
`ifdef TM1638_LED_EN
    input  logic [7:0]              led,
`endif
    output logic                    busy,
    output logic                    done,
    output logic                    clk1,
    output logic                    dio,
    output logic                    stb
);

    localparam int CNT_MAX = (CLK_DIV > STB_GAP) ? CLK_DIV : STB_GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(STB_GAP - 1);

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            phase, phase_n;
    logic [2:0]      bit_idx, bit_n;
    logic [4:0]      byte_idx, byte_n;
    logic            load;

    logic [NUM_DIGITS*4-1:0] hex_q;
    logic [NUM_DIGITS-1:0]   dp_q;
    logic [NUM_DIGITS-1:0]   blank_q;
    logic [2:0]              bright_q;
    logic                    on_q;
`ifdef TM1638_LED_EN
    logic [7:0]              led_q;
`endif

    logic [7:0] seg_byte [8];
    logic [3:0] addr;
    logic [7:0] cur_byte;

    for (genvar g = 0; g < 8; g++) begin : g_digit
        if (g < NUM_DIGITS) begin : g_used
            tm1638_seg_decode u_dec (
                .nibble (hex_q[4*g +: 4]),
                .dp     (dp_q[g]),
                .blank  (blank_q[g]),
                .seg    (seg_byte[g])
            );
        end else begin : g_unused
            assign seg_byte[g] = 8'h00;
        end
    end

    // byte_idx 2..17 maps to RAM address 0..15; 4-bit wrap makes 16,17 -> 14,15
    assign addr = byte_idx[3:0] - 4'd2;

    always_comb begin
        cur_byte = 8'h00;
        if (byte_idx == 5'd0)
            cur_byte = CMD_MODE;
        else if (byte_idx == 5'd1)
            cur_byte = CMD_ADDR;
        else if (byte_idx == LAST_BYTE)
            cur_byte = CMD_CTRL | {4'b0000, on_q, bright_q};
        else if (!addr[0])
            cur_byte = seg_byte[addr[3:1]];
`ifdef TM1638_LED_EN
        else
            cur_byte = {7'b0000000, led_q[addr[3:1]]};
`endif
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        phase_n = phase;
        bit_n   = bit_idx;
        byte_n  = byte_idx;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = SETUP;
                    load    = 1'b1;
                    cnt_n   = '0;
                    byte_n  = 5'd0;
                end
            end
            SETUP: begin
                if (cnt == DIV_LAST) begin
                    state_n = SHIFT;
                    cnt_n   = '0;
                    phase_n = 1'b0;
                    bit_n   = 3'd0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            SHIFT: begin
                if (cnt == DIV_LAST) begin
                    cnt_n   = '0;
                    phase_n = ~phase;
                    // Advance the bit only once its high phase has completed
                    if (phase) begin
                        bit_n = bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            byte_n = byte_idx + 5'd1;
                            if (is_window_end(byte_idx))
                                state_n = GAP;
                        end
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_n   = '0;
                    state_n = (byte_idx == NUM_BYTES) ? DONE : SETUP;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            phase    <= 1'b0;
            bit_idx  <= 3'd0;
            byte_idx <= 5'd0;
            hex_q    <= '0;
            dp_q     <= '0;
            blank_q  <= '0;
            bright_q <= 3'd0;
            on_q     <= 1'b0;
`ifdef TM1638_LED_EN
            led_q    <= 8'h00;
`endif
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            phase    <= phase_n;
            bit_idx  <= bit_n;
            byte_idx <= byte_n;
            if (load) begin
                hex_q    <= hex;
                dp_q     <= dp;
                blank_q  <= blank;
                bright_q <= bright;
                on_q     <= disp_on;
`ifdef TM1638_LED_EN
                led_q    <= led;
`endif
            end
        end
    end

    assign busy = (state == SETUP) || (state == SHIFT) || (state == GAP);
    assign done = (state == DONE);
    assign stb  = !((state == SETUP) || (state == SHIFT));
    assign clk1 = (state == SHIFT) ? phase : 1'b1;
    assign dio  = (state == SHIFT) ? cur_byte[bit_idx] : 1'b1;

endmodule
